// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider: per-channel modulo-N counter with a
// registered square wave of programmable high time and a period-start tick.
module clk_div_multi #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned NCH          = 2,
  parameter int unsigned CW           = 4,
  parameter int unsigned DEFAULT_DIV  = 1000,
  parameter int unsigned DEFAULT_HIGH = 500
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [CW-1:0]    i_wr_ch,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic [WIDTH-1:0] i_wr_high,
  output logic             o_wr_err,
  output logic [NCH-1:0]   o_clk_out,
  output logic [NCH-1:0]   o_tick
);

  localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_HIGH);
  localparam logic             DefClk  = (DEFAULT_HIGH == DEFAULT_DIV);

  logic             w_wr_bad;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_wr_high_clip;
  logic             r_wr_err;

  assign w_wr_bad       = (i_wr_div == '0) || (32'(i_wr_ch) >= NCH);
  assign w_wr_ok        = i_wr_en && !w_wr_bad;
  assign w_wr_high_clip = (i_wr_high > i_wr_div) ? i_wr_div : i_wr_high;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && w_wr_bad;
    end
  end

  assign o_wr_err = r_wr_err;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_act_div;
    logic [WIDTH-1:0] r_act_high;
    logic [WIDTH-1:0] r_sh_div;
    logic [WIDTH-1:0] r_sh_high;
    logic             r_clk_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] w_act_div_d;
    logic [WIDTH-1:0] w_act_high_d;
    logic             w_tick_d;
    logic             w_clk_d;
    logic             w_wrap;
    logic             w_sel;

    assign w_sel = w_wr_ok && (i_wr_ch == CW'(ch));

    always_comb begin
      w_cnt_d      = r_cnt;
      w_act_div_d  = r_act_div;
      w_act_high_d = r_act_high;
      w_tick_d     = 1'b0;
      w_wrap       = (r_cnt == (r_act_div - WIDTH'(1)));
      if (i_sync) begin
        w_cnt_d      = '0;
        w_act_div_d  = r_sh_div;
        w_act_high_d = r_sh_high;
      end else if (i_enable) begin
        if (w_wrap) begin
          // Shadows are sampled before any same-cycle write lands.
          w_cnt_d      = '0;
          w_act_div_d  = r_sh_div;
          w_act_high_d = r_sh_high;
          w_tick_d     = 1'b1;
        end else begin
          w_cnt_d = r_cnt + WIDTH'(1);
        end
      end
      // act_high <= act_div always, so the subtraction cannot underflow.
      w_clk_d = (w_cnt_d >= (w_act_div_d - w_act_high_d));
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_cnt      <= '0;
        r_act_div  <= DefDiv;
        r_act_high <= DefHigh;
        r_sh_div   <= DefDiv;
        r_sh_high  <= DefHigh;
        r_clk_out  <= DefClk;
        r_tick     <= 1'b0;
      end else begin
        r_cnt      <= w_cnt_d;
        r_act_div  <= w_act_div_d;
        r_act_high <= w_act_high_d;
        r_clk_out  <= w_clk_d;
        r_tick     <= w_tick_d;
        if (w_sel) begin
          r_sh_div  <= i_wr_div;
          r_sh_high <= w_wr_high_clip;
        end
      end
    end

    assign o_clk_out[ch] = r_clk_out;
    assign o_tick[ch]    = r_tick;
  end

endmodule
